// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor feedback blocks: period FSM states,
// the 16-bit saturation value and quadrature step decoding.
package motor_pkg;

  typedef enum logic {
    ST_MEASURE = 1'b0,
    ST_STALL   = 1'b1
  } period_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  // Position of an {a,b} pair on the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] quad_index(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Modulo-4 distance: +1 forward, -1 reverse, 2 means both bits flipped.
  function automatic step_e quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] delta;
    delta = quad_index(cur_ab) - quad_index(prev_ab);
    case (delta)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_FWD;
      2'd3:    return STEP_REV;
      default: return STEP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/tach_filter.sv
// Two-flop synchronizer followed by a glitch filter: a new level is taken only
// after FILTER_LEN consecutive identical synchronized samples.
module tach_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic valid
);

  localparam logic [7:0] LIMIT = 8'(FILTER_LEN - 1);

  logic [1:0] sync_r;
  logic [1:0] prime_r;
  logic [7:0] cnt_r;
  logic       level_r;
  logic       valid_r;

  // Synchronize, then load the first real sample and filter later changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r  <= 2'b00;
      prime_r <= 2'b00;
      cnt_r   <= 8'd0;
      level_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], din};
      prime_r <= {prime_r[0], 1'b1};
      if (!prime_r[1]) begin
        cnt_r <= 8'd0;
      end else if (!valid_r) begin
        level_r <= sync_r[1];
        valid_r <= 1'b1;
        cnt_r   <= 8'd0;
      end else if (sync_r[1] == level_r) begin
        cnt_r <= 8'd0;
      end else if (cnt_r == LIMIT) begin
        level_r <= sync_r[1];
        cnt_r   <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  assign level = level_r;
  assign valid = valid_r;

endmodule

// File: rtl/tach_decoder.sv
// Quadrature tach decoder: filtered A/B pins drive a signed position counter,
// an illegal-transition counter and a tick-based period/stall measurement.
module tach_decoder
  import motor_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int PRESCALE   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  tach,
  input  logic        clr_pos,
  output logic [15:0] position,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        dir,
  output logic        stalled,
  output logic [7:0]  err_cnt
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic          a_s, b_s, va_s, vb_s;
  logic [1:0]    cur_ab_s;
  logic          ab_valid_s;
  logic [1:0]    prev_ab_r;
  logic          prev_valid_r;
  step_e         step_s;
  logic          fwd_s, rev_s, err_s, move_s;
  logic [15:0]   presc_r;
  logic          tick_s;
  period_state_e state_r;
  logic [15:0]   tick_cnt_r;
  logic [15:0]   position_r;
  logic [15:0]   period_r;
  logic          period_valid_r;
  logic          dir_r;
  logic          stalled_r;
  logic [7:0]    err_cnt_r;

  tach_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din(tach[0]), .level(a_s), .valid(va_s)
  );

  tach_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din(tach[1]), .level(b_s), .valid(vb_s)
  );

  assign cur_ab_s   = {a_s, b_s};
  assign ab_valid_s = va_s & vb_s;

  // Classify the filtered transition; the first loaded sample never counts.
  always_comb begin
    step_s = STEP_NONE;
    if (ab_valid_s && prev_valid_r) begin
      step_s = quad_step(prev_ab_r, cur_ab_s);
    end else begin
      step_s = STEP_NONE;
    end
  end

  assign fwd_s  = (step_s == STEP_FWD);
  assign rev_s  = (step_s == STEP_REV);
  assign err_s  = (step_s == STEP_ERR);
  assign move_s = fwd_s | rev_s;
  assign tick_s = (presc_r == PRESC_MAX);

  // Previous AB, position (clear wins over a step) and saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_r    <= 2'b00;
      prev_valid_r <= 1'b0;
      position_r   <= 16'd0;
      err_cnt_r    <= 8'd0;
    end else begin
      prev_ab_r    <= cur_ab_s;
      prev_valid_r <= ab_valid_s;
      if (clr_pos) begin
        position_r <= 16'd0;
      end else if (fwd_s) begin
        position_r <= position_r + 16'd1;
      end else if (rev_s) begin
        position_r <= position_r - 16'd1;
      end
      if (err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  // Free-running timebase prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= 16'd0;
    end else if (tick_s) begin
      presc_r <= 16'd0;
    end else begin
      presc_r <= presc_r + 16'd1;
    end
  end

  // Period FSM; a step in the same cycle as saturation takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_STALL;
      tick_cnt_r     <= 16'd0;
      period_r       <= SAT_MAX;
      period_valid_r <= 1'b0;
      dir_r          <= 1'b1;
      stalled_r      <= 1'b1;
    end else begin
      period_valid_r <= 1'b0;
      case (state_r)
        ST_MEASURE: begin
          if (move_s) begin
            tick_cnt_r <= 16'd0;
            if (fwd_s == dir_r) begin
              period_r       <= tick_cnt_r;
              period_valid_r <= 1'b1;
            end else begin
              dir_r <= fwd_s;
            end
          end else if (tick_cnt_r == SAT_MAX) begin
            state_r        <= ST_STALL;
            stalled_r      <= 1'b1;
            period_r       <= SAT_MAX;
            period_valid_r <= 1'b1;
          end else if (tick_s) begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
          end
        end
        ST_STALL: begin
          if (move_s) begin
            state_r    <= ST_MEASURE;
            stalled_r  <= 1'b0;
            tick_cnt_r <= 16'd0;
            dir_r      <= fwd_s;
          end
        end
        default: begin
          state_r <= ST_STALL;
        end
      endcase
    end
  end

  assign position     = position_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign dir          = dir_r;
  assign stalled      = stalled_r;
  assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_tach_decoder.sv
// Directed bench for tach_decoder: a main instance (FILTER_LEN=4, PRESCALE=16)
// and a fast instance (FILTER_LEN=1, PRESCALE=2) for the wrap and stall runs.
module tb_tach_decoder;

  localparam int FL  = 4;
  localparam int PS  = 16;
  localparam int FL2 = 1;
  localparam int PS2 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  tach = 2'b00, tach2 = 2'b00;
  logic        clr_pos = 1'b0, clr_pos2 = 1'b0;
  logic [15:0] position, period, position2, period2;
  logic        period_valid, dir, stalled, period_valid2, dir2, stalled2;
  logic [7:0]  err_cnt, err_cnt2;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc;
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic [1:0]  ab [2];
  bit          meas [2];
  bit          mdir [2];
  int          last_s [2];

  always #5 clk = ~clk;

  tach_decoder #(.FILTER_LEN(FL), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .tach(tach), .clr_pos(clr_pos),
    .position(position), .period(period), .period_valid(period_valid),
    .dir(dir), .stalled(stalled), .err_cnt(err_cnt)
  );

  tach_decoder #(.FILTER_LEN(FL2), .PRESCALE(PS2)) dut2 (
    .clk(clk), .rst(rst), .tach(tach2), .clr_pos(clr_pos2),
    .position(position2), .period(period2), .period_valid(period_valid2),
    .dir(dir2), .stalled(stalled2), .err_cnt(err_cnt2)
  );

  // Edge index since reset release; timebase ticks land on multiples of PRESCALE.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every period strobe pops the value queued when the step was driven.
  always @(negedge clk) begin
    if (!rst && period_valid) begin
      if (q1.size() == 0) chk("dut1 spurious period_valid", 32'(period_valid), 32'd0);
      else chk("dut1 period", 32'(period), 32'(q1.pop_front()));
    end
    if (!rst && period_valid2) begin
      if (q2.size() == 0) chk("dut2 spurious period_valid", 32'(period_valid2), 32'd0);
      else chk("dut2 period", 32'(period2), 32'(q2.pop_front()));
    end
  end

  function automatic logic [1:0] gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input logic [1:0] i);
    case (i)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int count_ticks(input int s0, input int s1, input int p);
    int n = 0;
    for (int k = s0 + 1; k < s1; k++) if (k % p == 0) n++;
    return n;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one quadrature step (call between edges) and queue any expected period.
  task automatic step(input int d, input bit fwd);
    logic [1:0] idx;
    int s;
    idx = gidx(ab[d]);
    idx = fwd ? idx + 2'd1 : idx - 2'd1;
    ab[d] = gcode(idx);
    if (d == 0) tach  = {ab[0][0], ab[0][1]};
    else        tach2 = {ab[1][0], ab[1][1]};
    s = cyc + ((d == 0) ? FL + 3 : FL2 + 3);
    if (meas[d]) begin
      if (fwd == mdir[d]) begin
        if (d == 0) q1.push_back(16'(count_ticks(last_s[d], s, PS)));
        else        q2.push_back(16'(count_ticks(last_s[d], s, PS2)));
      end else begin
        mdir[d] = fwd;
      end
    end else begin
      meas[d] = 1'b1;
      mdir[d] = fwd;
    end
    last_s[d] = s;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ab[i] = 2'b00; meas[i] = 1'b0; mdir[i] = 1'b1; last_s[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_n(1);
    chk("reset position", 32'(position), 32'd0);
    chk("reset period", 32'(period), 32'hFFFF);
    chk("reset period_valid", 32'(period_valid), 32'd0);
    chk("reset dir", 32'(dir), 32'd1);
    chk("reset stalled", 32'(stalled), 32'd1);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    wait_n(10);

    // Forward rotation, phase-aligned so each 100-cycle gap spans 6 ticks.
    while (((cyc + FL + 3) % 4) != 0) wait_n(1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1);
      wait_n(100);
    end
    chk("fwd position", 32'(position), 32'd8);
    chk("fwd dir", 32'(dir), 32'd1);
    chk("fwd stalled", 32'(stalled), 32'd0);
    chk("fwd strobes consumed", 32'(q1.size()), 32'd0);

    // Three-cycle glitch on A must be rejected.
    tach[0] = ~tach[0];
    wait_n(3);
    tach[0] = ~tach[0];
    wait_n(20);
    chk("glitch position", 32'(position), 32'd8);
    chk("glitch err_cnt", 32'(err_cnt), 32'd0);

    // Reversal from a cleared position.
    clr_pos = 1'b1;
    wait_n(1);
    clr_pos = 1'b0;
    wait_n(5);
    chk("clr position", 32'(position), 32'd0);
    for (int i = 0; i < 4; i++) begin step(0, 1'b1); wait_n(100); end
    chk("rev mid position", 32'(position), 32'd4);
    for (int i = 0; i < 4; i++) begin step(0, 1'b0); wait_n(100); end
    chk("rev position", 32'(position), 32'd0);
    chk("rev dir", 32'(dir), 32'd0);

    // Illegal AB 00 -> 11.
    ab[0] = 2'b11;
    tach  = 2'b11;
    wait_n(20);
    chk("illegal err_cnt", 32'(err_cnt), 32'd1);
    chk("illegal position", 32'(position), 32'd0);
    chk("illegal dir", 32'(dir), 32'd0);

    // clr_pos landing on the same edge as a forward step.
    step(0, 1'b1);
    repeat (FL + 2) @(posedge clk);
    #1 clr_pos = 1'b1;
    wait_n(1);
    clr_pos = 1'b0;
    wait_n(10);
    chk("clr vs step position", 32'(position), 32'd0);
    step(0, 1'b0);
    wait_n(20);
    chk("wrap below zero", 32'(position), 32'hFFFF);
    step(0, 1'b1);
    wait_n(20);
    chk("wrap back to zero", 32'(position), 32'd0);

    // Reset in the middle of a measurement.
    step(0, 1'b1);
    wait_n(50);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst position", 32'(position), 32'd0);
    chk("midrst period", 32'(period), 32'hFFFF);
    chk("midrst period_valid", 32'(period_valid), 32'd0);
    chk("midrst dir", 32'(dir), 32'd1);
    chk("midrst stalled", 32'(stalled), 32'd1);
    chk("midrst err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 2; i++) begin meas[i] = 1'b0; mdir[i] = 1'b1; end
    wait_n(200);
    chk("post-rst position", 32'(position), 32'd0);
    chk("post-rst stalled", 32'(stalled), 32'd1);
    chk("post-rst period", 32'(period), 32'hFFFF);

    // Fast instance: climb to 0x7FFF, wrap to 0x8000, then stall.
    wait_n(10);
    for (int i = 0; i < 32767; i++) begin
      step(1, 1'b1);
      wait_n(2);
    end
    wait_n(10);
    chk("dut2 position 7fff", 32'(position2), 32'h7FFF);
    step(1, 1'b1);
    q2.push_back(16'hFFFF);
    meas[1] = 1'b0;
    wait_n(10);
    chk("dut2 wrap 8000", 32'(position2), 32'h8000);
    chk("dut2 not stalled", 32'(stalled2), 32'd0);
    wait_n(65535 * PS2 + 10);
    chk("dut2 stalled", 32'(stalled2), 32'd1);
    chk("dut2 stall period", 32'(period2), 32'hFFFF);
    chk("dut2 stall strobe seen", 32'(q2.size()), 32'd0);
    step(1, 1'b1);
    wait_n(10);
    chk("dut2 unstall", 32'(stalled2), 32'd0);
    chk("dut2 position after stall", 32'(position2), 32'h8001);
    chk("dut2 err_cnt", 32'(err_cnt2), 32'd0);

    wait_n(20);
    chk("dut1 queue drained", 32'(q1.size()), 32'd0);
    chk("dut2 queue drained", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
